// File: rtl/ula_pkg.sv
// Shared encodings for the multi-cycle execute unit: operation codes and FSM states.
// Code 0 (ULA_NOP) yields a zero result for undefined shift encodings.
package ula_pkg;

  typedef enum logic [4:0] {
    ULA_NOP    = 5'd0,
    ULA_ADD    = 5'd1,
    ULA_SUB    = 5'd2,
    ULA_SLL    = 5'd3,
    ULA_SLT    = 5'd4,
    ULA_SLTU   = 5'd5,
    ULA_XOR    = 5'd6,
    ULA_SRL    = 5'd7,
    ULA_SRA    = 5'd8,
    ULA_OR     = 5'd9,
    ULA_AND    = 5'd10,
    ULA_MUL    = 5'd11,
    ULA_MULH   = 5'd12,
    ULA_MULHSU = 5'd13,
    ULA_MULHU  = 5'd14,
    ULA_DIV    = 5'd15,
    ULA_DIVU   = 5'd16,
    ULA_REM    = 5'd17,
    ULA_REMU   = 5'd18
  } ula_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIN  = 2'd2
  } state_e;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  function automatic logic is_mext(input ula_op_e op);
    return op >= ULA_MUL;
  endfunction

  function automatic logic is_div(input ula_op_e op);
    return op >= ULA_DIV;
  endfunction

endpackage

// File: rtl/ula_decode.sv
// Combinational decode of {funct7, funct3} and the datapath ula_op into an operation code.
module ula_decode
  import ula_pkg::*;
(
  input  logic [9:0] inst,
  input  logic [1:0] ula_op,
  output ula_op_e    op
);

  logic [6:0] funct7;
  logic [2:0] funct3;

  assign funct7 = inst[9:3];
  assign funct3 = inst[2:0];

  always_comb begin
    op = ULA_ADD;
    case (ula_op)
      2'b00: op = ULA_ADD;
      2'b01: begin
        case (funct3[2:1])
          2'b10:   op = ULA_SLT;
          2'b11:   op = ULA_SLTU;
          default: op = ULA_SUB;
        endcase
      end
      default: begin
        if (ula_op == 2'b10 && funct7 == F7_MULDIV) begin
          case (funct3)
            3'b000:  op = ULA_MUL;
            3'b001:  op = ULA_MULH;
            3'b010:  op = ULA_MULHSU;
            3'b011:  op = ULA_MULHU;
            3'b100:  op = ULA_DIV;
            3'b101:  op = ULA_DIVU;
            3'b110:  op = ULA_REM;
            default: op = ULA_REMU;
          endcase
        end else begin
          case (funct3)
            3'b000:  op = (ula_op == 2'b10 && funct7 == F7_ALT) ? ULA_SUB : ULA_ADD;
            3'b001:  op = ULA_SLL;
            3'b010:  op = ULA_SLT;
            3'b011:  op = ULA_SLTU;
            3'b100:  op = ULA_XOR;
            3'b101: begin
              if (funct7 == F7_BASE)     op = ULA_SRL;
              else if (funct7 == F7_ALT) op = ULA_SRA;
              else                       op = ULA_NOP;
            end
            3'b110:  op = ULA_OR;
            default: op = ULA_AND;
          endcase
        end
      end
    endcase
  end

endmodule

// File: rtl/ula_mc.sv
// Multi-cycle execute unit: single-cycle base ops plus an iterative shift-add multiplier
// and restoring divider that share one 2*XLEN shift register.
module ula_mc
  import ula_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [9:0]      inst,
  input  logic [1:0]      ula_op,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int SW = $clog2(XLEN);

  ula_op_e dec_op;

  ula_decode u_decode (
    .inst   (inst),
    .ula_op (ula_op),
    .op     (dec_op)
  );

  state_e              state;
  ula_op_e             op_r;
  logic                neg_r;
  logic [5:0]          cnt;
  logic [XLEN-1:0]     opnd_r;
  logic [2*XLEN-1:0]   sr;

  logic [SW-1:0]       shamt;
  logic [XLEN-1:0]     base_res;

  assign shamt = op_b[SW-1:0];

  always_comb begin
    base_res = '0;
    case (dec_op)
      ULA_ADD:  base_res = op_a + op_b;
      ULA_SUB:  base_res = op_a - op_b;
      ULA_SLL:  base_res = op_a << shamt;
      ULA_SLT:  base_res = XLEN'($signed(op_a) < $signed(op_b));
      ULA_SLTU: base_res = XLEN'(op_a < op_b);
      ULA_XOR:  base_res = op_a ^ op_b;
      ULA_SRL:  base_res = op_a >> shamt;
      ULA_SRA:  base_res = $signed(op_a) >>> shamt;
      ULA_OR:   base_res = op_a | op_b;
      ULA_AND:  base_res = op_a & op_b;
      default:  base_res = '0;
    endcase
  end

  logic            a_signed, b_signed, sign_a, sign_b, neg_start;
  logic            div_zero, div_ovf, is_quot;
  logic [XLEN-1:0] mag_a, mag_b, special_res;

  // Operands are reduced to magnitudes up front; the sign is reapplied in FIN.
  always_comb begin
    a_signed    = dec_op inside {ULA_MULH, ULA_MULHSU, ULA_DIV, ULA_REM};
    b_signed    = dec_op inside {ULA_MULH, ULA_DIV, ULA_REM};
    sign_a      = a_signed & op_a[XLEN-1];
    sign_b      = b_signed & op_b[XLEN-1];
    mag_a       = sign_a ? -op_a : op_a;
    mag_b       = sign_b ? -op_b : op_b;
    neg_start   = (dec_op inside {ULA_REM, ULA_REMU}) ? sign_a : (sign_a ^ sign_b);
    is_quot     = dec_op inside {ULA_DIV, ULA_DIVU};
    div_zero    = is_div(dec_op) && (op_b == '0);
    div_ovf     = (dec_op inside {ULA_DIV, ULA_REM}) &&
                  (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
    special_res = '0;
    if (div_zero)     special_res = is_quot ? '1 : op_a;
    else if (div_ovf) special_res = is_quot ? op_a : '0;
  end

  logic [XLEN:0]     mul_sum, div_t, div_diff;
  logic              div_ge;
  logic [2*XLEN-1:0] mul_next, div_next;

  always_comb begin
    mul_sum  = {1'b0, sr[2*XLEN-1:XLEN]} + (sr[0] ? {1'b0, opnd_r} : '0);
    mul_next = {mul_sum, sr[XLEN-1:1]};
    div_t    = {sr[2*XLEN-1:XLEN], sr[XLEN-1]};
    div_diff = div_t - {1'b0, opnd_r};
    div_ge   = ~div_diff[XLEN];
    div_next = {(div_ge ? div_diff[XLEN-1:0] : div_t[XLEN-1:0]), sr[XLEN-2:0], div_ge};
  end

  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, fin_res;

  always_comb begin
    prod_fix = neg_r ? -sr : sr;
    quo_fix  = neg_r ? -sr[XLEN-1:0] : sr[XLEN-1:0];
    rem_fix  = neg_r ? -sr[2*XLEN-1:XLEN] : sr[2*XLEN-1:XLEN];
    case (op_r)
      ULA_MUL:                          fin_res = sr[XLEN-1:0];
      ULA_MULH, ULA_MULHSU, ULA_MULHU:  fin_res = prod_fix[2*XLEN-1:XLEN];
      ULA_DIV, ULA_DIVU:                fin_res = quo_fix;
      default:                          fin_res = rem_fix;
    endcase
  end

  // Control FSM and the shared shift register; done is a one-cycle registered pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      op_r   <= ULA_NOP;
      neg_r  <= 1'b0;
      cnt    <= '0;
      opnd_r <= '0;
      sr     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (!is_mext(dec_op)) begin
              result <= base_res;
              done   <= 1'b1;
            end else if (div_zero || div_ovf) begin
              result <= special_res;
              done   <= 1'b1;
            end else begin
              op_r   <= dec_op;
              neg_r  <= neg_start;
              opnd_r <= is_div(dec_op) ? mag_b : mag_a;
              sr     <= {{XLEN{1'b0}}, (is_div(dec_op) ? mag_a : mag_b)};
              cnt    <= 6'(XLEN - 1);
              busy   <= 1'b1;
              state  <= ITER;
            end
          end
        end
        ITER: begin
          sr  <= is_div(op_r) ? div_next : mul_next;
          cnt <= cnt - 6'd1;
          if (cnt == 6'd0) state <= FIN;
        end
        FIN: begin
          result <= fin_res;
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ula_mc.sv
// Directed self-checking bench for ula_mc (XLEN=32) with hand-computed expected values.
module tb_ula_mc;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [9:0]  inst;
  logic [1:0]  ula_op;
  logic [31:0] op_a, op_b;
  logic        busy, done;
  logic [31:0] result;

  int vectors = 0;
  int miscompares = 0;

  ula_mc #(.XLEN(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .inst   (inst),
    .ula_op (ula_op),
    .op_a   (op_a),
    .op_b   (op_b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where done is seen, so the next call
  // drives its start in the done cycle.
  task automatic applyStimulus(input string tag, input logic [1:0] uop, input logic [9:0] ins,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] exp, input int exp_lat);
    int lat;
    int bcnt;
    start = 1'b1; ula_op = uop; inst = ins; op_a = a; op_b = b;
    @(negedge clk);
    start = 1'b0; op_a = $urandom; op_b = $urandom; inst = 10'($urandom); ula_op = 2'($urandom);
    lat = 1;
    bcnt = 0;
    while (!done && lat < 100) begin
      if (busy) bcnt++;
      @(negedge clk);
      lat++;
    end
    if (busy) bcnt++;
    checkOutput({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    checkOutput({tag, "_res"}, {32'd0, result}, {32'd0, exp});
    checkOutput({tag, "_busy"}, 64'(bcnt), 64'(exp_lat - 1));
  endtask

  initial begin
    int dcnt;
    int lat;
    logic [31:0] seen;

    rst = 1'b1; start = 1'b0; inst = '0; ula_op = '0; op_a = '0; op_b = '0;
    #1;
    checkOutput("reset_busy", {63'd0, busy}, 64'd0);
    checkOutput("reset_done", {63'd0, done}, 64'd0);
    checkOutput("reset_result", {32'd0, result}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    applyStimulus("sub",      2'b10, 10'b0100000_000, 32'd5, 32'd7, 32'hFFFF_FFFE, 1);
    applyStimulus("addi_alt", 2'b11, 10'b0100000_000, 32'd5, 32'd7, 32'd12, 1);
    applyStimulus("add_ls",   2'b00, 10'b1111111_111, 32'h10, 32'hFFFF_FFF0, 32'd0, 1);
    applyStimulus("add_unk",  2'b10, 10'b0000010_000, 32'd5, 32'd7, 32'd12, 1);
    applyStimulus("br_slt",   2'b01, 10'b0000000_100, 32'hFFFF_FFFF, 32'd1, 32'd1, 1);
    applyStimulus("br_sltu",  2'b01, 10'b0000000_110, 32'hFFFF_FFFF, 32'd1, 32'd0, 1);
    applyStimulus("br_sub",   2'b01, 10'b0000000_000, 32'd9, 32'd7, 32'd2, 1);
    applyStimulus("sll",      2'b10, 10'b0000000_001, 32'd1, 32'h25, 32'h20, 1);
    applyStimulus("sra",      2'b10, 10'b0100000_101, 32'h8000_0000, 32'd4, 32'hF800_0000, 1);
    applyStimulus("srl",      2'b10, 10'b0000000_101, 32'h8000_0000, 32'd4, 32'h0800_0000, 1);
    applyStimulus("sh_bad",   2'b10, 10'b0000010_101, 32'h8000_0000, 32'd4, 32'd0, 1);
    applyStimulus("xor",      2'b11, 10'b0000000_100, 32'hF0F0, 32'h0FF0, 32'hFF00, 1);
    applyStimulus("or",       2'b10, 10'b0000000_110, 32'hC, 32'hA, 32'hE, 1);
    applyStimulus("and",      2'b10, 10'b0000000_111, 32'hC, 32'hA, 32'h8, 1);
    applyStimulus("slt",      2'b10, 10'b0000000_010, 32'hFFFF_FFFE, 32'd3, 32'd1, 1);
    applyStimulus("sltu",     2'b10, 10'b0000000_011, 32'hFFFF_FFFE, 32'd3, 32'd0, 1);

    applyStimulus("mulh",     2'b10, 10'b0000001_001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34);
    applyStimulus("mul_big",  2'b10, 10'b0000001_000, 32'h8000_0000, 32'h8000_0000, 32'd0, 34);
    applyStimulus("mul",      2'b10, 10'b0000001_000, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, 34);
    applyStimulus("mulhu",    2'b10, 10'b0000001_011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
    applyStimulus("mulhsu",   2'b10, 10'b0000001_010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34);
    applyStimulus("div",      2'b10, 10'b0000001_100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
    applyStimulus("rem",      2'b10, 10'b0000001_110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
    applyStimulus("div_nb",   2'b10, 10'b0000001_100, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 34);
    applyStimulus("rem_nb",   2'b10, 10'b0000001_110, 32'd7, 32'hFFFF_FFFE, 32'd1, 34);
    applyStimulus("divu",     2'b10, 10'b0000001_101, 32'd100, 32'd7, 32'd14, 34);
    applyStimulus("remu",     2'b10, 10'b0000001_111, 32'd100, 32'd7, 32'd2, 34);
    applyStimulus("divu_z",   2'b10, 10'b0000001_101, 32'd55, 32'd0, 32'hFFFF_FFFF, 1);
    applyStimulus("div_z",    2'b10, 10'b0000001_100, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    applyStimulus("remu_z",   2'b10, 10'b0000001_111, 32'h1234, 32'd0, 32'h1234, 1);
    applyStimulus("div_ovf",  2'b10, 10'b0000001_100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    applyStimulus("rem_ovf",  2'b10, 10'b0000001_110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);

    // done is a single pulse and result is held afterwards
    applyStimulus("mul_hold", 2'b10, 10'b0000001_000, 32'd7, 32'd6, 32'd42, 34);
    @(negedge clk);
    checkOutput("pulse_done", {63'd0, done}, 64'd0);
    checkOutput("hold_result", {32'd0, result}, 64'd42);

    // a second start mid-DIV is ignored
    start = 1'b1; ula_op = 2'b10; inst = 10'b0000001_100; op_a = 32'd100; op_b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    start = 1'b1; ula_op = 2'b00; op_a = 32'd3; op_b = 32'd4;
    @(negedge clk);
    start = 1'b0;
    dcnt = 0; lat = 7; seen = '0;
    for (int i = 0; i < 50; i++) begin
      if (done) begin
        if (dcnt == 0) begin
          checkOutput("ign_lat", 64'(lat), 64'd34);
          seen = result;
        end
        dcnt++;
      end
      @(negedge clk);
      lat++;
    end
    checkOutput("ign_dones", 64'(dcnt), 64'd1);
    checkOutput("ign_result", {32'd0, seen}, 64'd14);

    // asynchronous reset during MULHU discards the operation
    start = 1'b1; ula_op = 2'b10; inst = 10'b0000001_011; op_a = 32'hFFFF_FFFF; op_b = 32'hFFFF_FFFF;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("arst_busy", {63'd0, busy}, 64'd0);
    checkOutput("arst_done", {63'd0, done}, 64'd0);
    checkOutput("arst_result", {32'd0, result}, 64'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    checkOutput("arst_nodone", 64'(dcnt), 64'd0);
    applyStimulus("post_add", 2'b00, 10'b0000000_000, 32'd3, 32'd4, 32'd7, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ula_mc.md
# ula_mc

Multi-cycle execute unit for the RV32/RV64 core, replacing the separate ALU-control decode plus single-cycle ALU. It takes `ula_op` and `{funct7,funct3}` exactly as the datapath provides them and decodes the base integer operations. It adds the M extension (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) with an iterative shift-add multiplier and a restoring divider behind a start/busy/done handshake. It sits in the EX stage; the pipeline stalls while `busy` is high.

## Interface
- `XLEN`, default 32: operand width; power of two, at least 8.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE.
- `inst`  in  10  `{funct7[6:0], funct3[2:0]}`.
- `ula_op`  in  2  00 = load/store/AUIPC add, 01 = branch compare, 10 = R-type, 11 = I-type.
- `op_a`  in  XLEN  rs1 / first operand.
- `op_b`  in  XLEN  rs2 or immediate.
- `busy`  out  1  iterative operation in progress; reset 0.
- `done`  out  1  one-cycle pulse; `result` is valid; reset 0.
- `result`  out  XLEN  registered result, held until the next `done`; reset 0.

## Operation
- Decode with funct7 = 0000001 and `ula_op` = 10:
  - M operation selected by funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- Other decodes:
  - `ula_op` 00 → ADD.
  - `ula_op` 01 → funct3 1x0/1x1 select SLT (10x) or SLTU (11x); otherwise SUB.
  - `ula_op` 10/11 → standard funct3 map: ADD, SLL, SLT, SLTU, XOR, SRL/SRA, OR, AND.
  - SUB only for R-type funct3 000 with funct7 0100000. Unknown R-type funct7 on 000 → ADD.
  - funct3 101: funct7 0000000 → SRL, 0100000 → SRA, anything else → result 0.
- Shift amount is `op_b[$clog2(XLEN)-1:0]`. SLT/SLTU return zero-extended 0/1.
- FSM states:
  - IDLE: `start` with a base op registers the result and asserts `done` next cycle; no busy.
  - IDLE: `start` with an M op latches operand magnitudes, result signs and the op, then goes to ITER.
  - ITER: one bit per cycle, 6-bit counter from XLEN-1 down to 0. At 0 → FIN.
  - FIN: apply sign correction (two's-complement negate), select low/high half or quotient/remainder, write `result`, pulse `done`, go to IDLE.
- Signedness:
  - MULH: both operands signed.
  - MULHSU: `op_a` signed, `op_b` unsigned.
  - MULHU, DIVU, REMU: unsigned.
  - Quotient sign = sign(a) XOR sign(b). Remainder sign = sign(a).
- Division special cases, resolved in IDLE with base-op latency:
  - divisor 0 → quotient all-ones, remainder = `op_a`.
  - signed overflow, -2^(XLEN-1) / -1 → quotient = `op_a`, remainder 0.
- `start` while busy is ignored. Operands need not be held after the start cycle.

## Timing
- Base op and division special cases: `done` and `result` valid in the cycle after `start` is sampled (latency 1).
- M op: `start` sampled at edge k; ITER occupies edges k+1..k+XLEN; FIN at edge k+XLEN+1. `done` is high in the following cycle, giving latency XLEN+2 (34 for XLEN=32).
- `busy` is high from the cycle after the start edge through the FIN cycle, and low in the `done` cycle.
- Back-to-back: a new `start` is accepted in the `done` cycle.
- Asynchronous `rst` at any point → IDLE with `busy`=0, `done`=0, `result`=0. The in-flight operation is discarded and no `done` follows.

## Structure
- Package `ula_pkg` holds:
  - the 5-bit op encoding: base codes ULA_ADD..ULA_AND keep their existing values 1..10; ULA_MUL..ULA_REMU are 11..18;
  - FSM state enum IDLE/ITER/FIN.
- Sub-module `ula_decode`: purely combinational `{inst, ula_op}` → 5-bit op code. It can be reused by a future single-cycle path.
- Datapath, FSM, multiplier and divider stay in `ula_mc`, sharing one 2·XLEN shift register.

## Test plan
- `ula_op`=10, inst=0100000_000, a=5, b=7 → `done` one cycle later, result=0xFFFFFFFE; `busy` never high.
- MULH with a=0x80000000, b=0x80000000 → `busy` for 33 cycles, `done` at start+34, result=0x40000000. MUL with the same operands → 0.
- DIV a=-7, b=2 → result=-3 (0xFFFFFFFD); REM with the same operands → -1.
- DIVU with b=0 → result=0xFFFFFFFF at latency 1. DIV 0x80000000 / 0xFFFFFFFF → 0x80000000. REM of the same → 0.
- Second `start` pulsed mid-DIV → ignored; exactly one `done`. A new `start` in the `done` cycle is accepted.
- `rst` asserted asynchronously at iteration 10 of MULHU → outputs zero immediately; after release no `done` appears. A following ADD of 3+4 returns 7.
